muldiv_seq: RTL and testbench

- Sequencer for the shared multiplier and iterative divider used by the EX stage of the 5-stage MIPS core.
- Accepts one MULT/MULTU/DIV/DIVU op from EX and drives operands/start to the external mul and div units.
- Counts multiplier latency, raises the EX stall request until the result is ready, and holds the HI/LO write until the pipeline advances.
- Supports annul on flush.

---
 rtl/muldiv_pkg.sv | 32 +++
 rtl/muldiv_lat_cnt.sv | 28 ++
 rtl/muldiv_seq.sv | 180 ++++++++++++++++++
 tb/tb_muldiv_seq.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the EX-stage mul/div sequencer.
// The watchdog is built in only when MULDIV_WDOG_EN is defined.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL_WAIT,
        S_DIV_RUN,
        S_DONE
    } state_e;

    localparam logic [31:0] DIV_ZERO_LO = 32'hFFFF_FFFF;

    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

    function automatic logic is_div(op_e op);
        return op[1];
    endfunction

    function automatic logic is_signed(op_e op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/muldiv_lat_cnt.sv
// Loadable down-counter with zero flag; used for mul latency
// and, with MULDIV_WDOG_EN, the divider watchdog.
module muldiv_lat_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/muldiv_seq.sv
// Mul/div sequencer for EX: issues ops, stalls, holds HI/LO write.
// Optional divider watchdog enabled by MULDIV_WDOG_EN.
import muldiv_pkg::*;

module muldiv_seq #(
    parameter int MUL_LAT     = 1,
    parameter int DIV_TIMEOUT = 40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] src_a_i,
    input  logic [31:0] src_b_i,
    input  logic        ex_adv_i,
    input  logic        annul_i,
    output logic        stallreq_o,
    output logic        res_valid_o,
    output logic        hi_we_o,
    output logic        lo_we_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        err_o,
    output logic        mul_signed_o,
    output logic [31:0] mul_a_o,
    output logic [31:0] mul_b_o,
    input  logic [63:0] mul_result_i,
    output logic        div_start_o,
    output logic        div_signed_o,
    output logic [31:0] div_a_o,
    output logic [31:0] div_b_o,
    output logic        div_annul_o,
    input  logic [63:0] div_result_i,
    input  logic        div_ready_i
);

    localparam int CW = $clog2((DIV_TIMEOUT > 8 ? DIV_TIMEOUT : 8) + 1);

    state_e      state_q, state_d;
    op_e         op_q, op_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic        err_q, err_d;
    logic        dann_q, dann_d;
    logic        cnt_load, cnt_dec, cnt_zero;
    logic [CW-1:0] cnt_val;

    muldiv_lat_cnt #(.W(CW)) u_cnt (
        .clk       (clk),
        .rst       (rst),
        .load_i    (cnt_load),
        .load_val_i(cnt_val),
        .dec_i     (cnt_dec),
        .zero_o    (cnt_zero)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        err_d    = err_q;
        dann_d   = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        cnt_val  = '0;
        if (annul_i) begin
            state_d = S_IDLE;
            err_d   = 1'b0;
            dann_d  = (state_q == S_DIV_RUN);
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (op_valid_i) begin
                        op_d = op_e'(op_i);
                        a_d  = src_a_i;
                        b_d  = src_b_i;
                        if (!op_i[1]) begin
                            state_d  = S_MUL_WAIT;
                            cnt_load = 1'b1;
                            cnt_val  = CW'(MUL_LAT - 1);
                        end else if (src_b_i == '0) begin
                            // Divide by zero never reaches the div unit
                            state_d = S_DONE;
                            hi_d    = src_a_i;
                            lo_d    = DIV_ZERO_LO;
                        end else begin
                            state_d  = S_DIV_RUN;
`ifdef MULDIV_WDOG_EN
                            cnt_load = 1'b1;
                            cnt_val  = CW'(DIV_TIMEOUT - 1);
`endif
                        end
                    end
                end
                S_MUL_WAIT: begin
                    cnt_dec = 1'b1;
                    if (cnt_zero) begin
                        hi_d    = mul_result_i[63:32];
                        lo_d    = mul_result_i[31:0];
                        state_d = S_DONE;
                    end
                end
                S_DIV_RUN: begin
                    if (div_ready_i) begin
                        hi_d    = div_result_i[63:32];
                        lo_d    = div_result_i[31:0];
                        state_d = S_DONE;
                    end
`ifdef MULDIV_WDOG_EN
                    else begin
                        cnt_dec = 1'b1;
                        if (cnt_zero) begin
                            hi_d    = '0;
                            lo_d    = '0;
                            err_d   = 1'b1;
                            dann_d  = 1'b1;
                            state_d = S_DONE;
                        end
                    end
`endif
                end
                S_DONE: begin
                    if (ex_adv_i) begin
                        state_d = S_IDLE;
                        err_d   = 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= OP_MULT;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            err_q   <= 1'b0;
            dann_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            err_q   <= err_d;
            dann_q  <= dann_d;
        end
    end

    assign stallreq_o = (state_q == S_IDLE) ?
                        ((op_valid_i & ~annul_i) ? Stop : NoStop) :
                        ((state_q == S_DONE) ? NoStop : Stop);

    assign res_valid_o  = (state_q == S_DONE);
    assign hi_we_o      = res_valid_o;
    assign lo_we_o      = res_valid_o;
    assign hi_o         = hi_q;
    assign lo_o         = lo_q;
`ifdef MULDIV_WDOG_EN
    assign err_o        = err_q;
`else
    assign err_o        = 1'b0;
`endif
    assign mul_signed_o = (state_q == S_MUL_WAIT) & is_signed(op_q);
    assign mul_a_o      = a_q;
    assign mul_b_o      = b_q;
    assign div_start_o  = (state_q == S_DIV_RUN);
    assign div_signed_o = (state_q == S_DIV_RUN) & is_signed(op_q);
    assign div_a_o      = a_q;
    assign div_b_o      = b_q;
    assign div_annul_o  = dann_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq with behavioural mul/div units.
// Watchdog scenario runs only when MULDIV_WDOG_EN is defined.
module tb_muldiv_seq;

    localparam int MUL_LAT     = 1;
    localparam int DIV_TIMEOUT = 40;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid_i, ex_adv_i, annul_i;
    logic [1:0]  op_i;
    logic [31:0] src_a_i, src_b_i;
    logic        stallreq_o, res_valid_o, hi_we_o, lo_we_o, err_o;
    logic [31:0] hi_o, lo_o;
    logic        mul_signed_o, div_start_o, div_signed_o, div_annul_o;
    logic [31:0] mul_a_o, mul_b_o, div_a_o, div_b_o;
    logic [63:0] mul_result_i, div_result_i;
    logic        div_ready_i;

    int passed = 0;
    int total  = 0;
    int div_lat = 1;
    int run_cnt = 0;
    int start_total = 0;

    always #5 clk = ~clk;

    muldiv_seq #(.MUL_LAT(MUL_LAT), .DIV_TIMEOUT(DIV_TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .op_valid_i(op_valid_i), .op_i(op_i),
        .src_a_i(src_a_i), .src_b_i(src_b_i),
        .ex_adv_i(ex_adv_i), .annul_i(annul_i),
        .stallreq_o(stallreq_o), .res_valid_o(res_valid_o),
        .hi_we_o(hi_we_o), .lo_we_o(lo_we_o),
        .hi_o(hi_o), .lo_o(lo_o), .err_o(err_o),
        .mul_signed_o(mul_signed_o), .mul_a_o(mul_a_o),
        .mul_b_o(mul_b_o), .mul_result_i(mul_result_i),
        .div_start_o(div_start_o), .div_signed_o(div_signed_o),
        .div_a_o(div_a_o), .div_b_o(div_b_o),
        .div_annul_o(div_annul_o), .div_result_i(div_result_i),
        .div_ready_i(div_ready_i)
    );

    // Architectural result of a MIPS mul/div op: {HI, LO}
    function automatic logic [63:0] ref_res(input logic [1:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb, sq, sr;
        logic [63:0] ua, ub, uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        if (op == 2'b00) return 64'(sa * sb);
        if (op == 2'b01) return ua * ub;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (op == 2'b10) begin
            sq = sa / sb;
            sr = sa % sb;
            return {sr[31:0], sq[31:0]};
        end
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
    endfunction

    always_comb begin
        mul_result_i = ref_res({1'b0, ~mul_signed_o}, mul_a_o, mul_b_o);
        div_result_i = ref_res({1'b1, ~div_signed_o}, div_a_o, div_b_o);
    end

    assign div_ready_i = div_start_o && (div_lat > 0) &&
                         (run_cnt == div_lat - 1);

    always @(posedge clk) begin
        if (div_start_o) begin
            run_cnt     <= run_cnt + 1;
            start_total <= start_total + 1;
        end else begin
            run_cnt <= 0;
        end
    end

    // Present an op and wait for res_valid; returns stalled cycles.
    task automatic issue(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, output int stalls,
                         output bit to);
        op_valid_i = 1'b1;
        op_i = op;
        src_a_i = a;
        src_b_i = b;
        stalls = 0;
        to = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (res_valid_o) begin
                to = 1'b0;
                break;
            end
            if (stallreq_o) stalls++;
            @(posedge clk);
            #1;
        end
        if (to) begin
            @(posedge clk);
            #1;
            annul_i = 1'b1;
            @(posedge clk);
            #1;
            annul_i = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic retire();
        @(posedge clk);
        #1;
        ex_adv_i = 1'b1;
        @(posedge clk);
        #1;
        ex_adv_i = 1'b0;
        op_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        op_valid_i = 1'b0;
        ex_adv_i = 1'b0;
        annul_i = 1'b0;
        op_i = 2'b00;
        src_a_i = '0;
        src_b_i = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({stallreq_o, res_valid_o, hi_we_o, lo_we_o, err_o, mul_signed_o,
             div_start_o, div_signed_o, div_annul_o} !== 9'b0 ||
            {hi_o, lo_o, mul_a_o, mul_b_o, div_a_o, div_b_o} !== '0)
            $display("FAIL reset: ctl=%b data nonzero hi=%h lo=%h req all 0",
                     {stallreq_o, res_valid_o, div_start_o, err_o}, hi_o, lo_o);
        else passed++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_mult();
        int st;
        bit to;
        issue(2'b00, 32'hFFFF_FFFE, 32'd3, st, to);
        total++;
        if (to || st !== 2)
            $display("FAIL mult_stall: got %0d to=%0d req 2", st, to);
        else passed++;
        total++;
        if ({hi_o, lo_o} !== 64'hFFFF_FFFF_FFFF_FFFA || !hi_we_o || !lo_we_o)
            $display("FAIL mult_res: got %h_%h req ffffffff_fffffffa", hi_o, lo_o);
        else passed++;
        retire();
    endtask

    task automatic test_divu();
        int st, s0;
        bit to;
        div_lat = 33;
        s0 = start_total;
        issue(2'b11, 32'd100, 32'd7, st, to);
        total++;
        if (to || st !== 34 || stallreq_o)
            $display("FAIL divu_stall: got %0d stall=%b req 34", st, stallreq_o);
        else passed++;
        total++;
        if (start_total - s0 !== 33)
            $display("FAIL divu_start: got %0d req 33", start_total - s0);
        else passed++;
        total++;
        if (hi_o !== 32'd2 || lo_o !== 32'd14)
            $display("FAIL divu_res: got %0d/%0d req 2/14", hi_o, lo_o);
        else passed++;
        retire();
    endtask

    task automatic test_div_zero_hold();
        int st, s0;
        bit to;
        s0 = start_total;
        issue(2'b10, 32'd5, 32'd0, st, to);
        total++;
        if (to || st !== 1 || hi_o !== 32'd5 || lo_o !== 32'hFFFF_FFFF)
            $display("FAIL divzero: got st=%0d %h_%h req 1 00000005_ffffffff",
                     st, hi_o, lo_o);
        else passed++;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
        total++;
        if (!res_valid_o || hi_o !== 32'd5 || start_total !== s0 || stallreq_o)
            $display("FAIL done_hold: valid=%b hi=%h starts=%0d req 1 5 %0d",
                     res_valid_o, hi_o, start_total, s0);
        else passed++;
        retire();
        @(negedge clk);
        total++;
        if (res_valid_o || stallreq_o)
            $display("FAIL back_to_idle: valid=%b stall=%b req 0 0",
                     res_valid_o, stallreq_o);
        else passed++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_annul();
        int st;
        bit to;
        div_lat = 100;
        op_valid_i = 1'b1;
        op_i = 2'b11;
        src_a_i = 32'd1000;
        src_b_i = 32'd3;
        @(posedge clk);
        repeat (9) @(posedge clk);
        #1;
        annul_i = 1'b1;
        op_valid_i = 1'b0;
        @(posedge clk);
        #1;
        annul_i = 1'b0;
        @(negedge clk);
        total++;
        if (!div_annul_o || div_start_o || res_valid_o || hi_we_o || stallreq_o)
            $display("FAIL annul_pulse: ann=%b start=%b we=%b stall=%b req 1 0 0 0",
                     div_annul_o, div_start_o, hi_we_o, stallreq_o);
        else passed++;
        @(negedge clk);
        total++;
        if (div_annul_o || res_valid_o)
            $display("FAIL annul_once: ann=%b valid=%b req 0 0",
                     div_annul_o, res_valid_o);
        else passed++;
        @(posedge clk);
        #1;
        issue(2'b01, 32'd7, 32'd6, st, to);
        total++;
        if (to || hi_o !== 32'd0 || lo_o !== 32'd42)
            $display("FAIL post_annul_multu: got %0d:%0d req 0:42", hi_o, lo_o);
        else passed++;
        retire();
    endtask

    task automatic test_random();
        int st, exp_st;
        bit to;
        logic [1:0] op;
        logic [31:0] a, b;
        logic [63:0] exp;
        for (int n = 0; n < 30; n++) begin
            op = 2'($urandom_range(0, 3));
            a = $urandom;
            b = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 1) == 1) b = b & 32'h0000_00FF;
            div_lat = $urandom_range(1, 10);
            exp = ref_res(op, a, b);
            exp_st = !op[1] ? MUL_LAT + 1 : (b == 0) ? 1 : div_lat + 1;
            issue(op, a, b, st, to);
            total++;
            if (to || st !== exp_st || {hi_o, lo_o} !== exp || err_o)
                $display("FAIL rand_%0d op=%0d: got st=%0d %h req st=%0d %h",
                         n, op, st, {hi_o, lo_o}, exp_st, exp);
            else passed++;
            retire();
        end
    endtask

    task automatic test_wdog();
`ifdef MULDIV_WDOG_EN
        int st;
        bit to;
        div_lat = 0;
        issue(2'b10, 32'd9, 32'd3, st, to);
        total++;
        if (to || st !== DIV_TIMEOUT + 1 || !err_o || hi_o !== 0 ||
            lo_o !== 0 || !div_annul_o)
            $display("FAIL wdog: st=%0d err=%b ann=%b %h_%h req %0d 1 1 0",
                     st, err_o, div_annul_o, hi_o, lo_o, DIV_TIMEOUT + 1);
        else passed++;
        retire();
        @(negedge clk);
        total++;
        if (err_o)
            $display("FAIL wdog_err_clear: got %b req 0", err_o);
        else passed++;
        @(posedge clk);
        #1;
`endif
    endtask

    initial begin
        test_reset();
        test_mult();
        test_divu();
        test_div_zero_hold();
        test_annul();
        test_random();
        test_wdog();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
